// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
//   EX/MEM pipeline register of the 5-stage CPU. Captures the execute-stage
//   ALU result, Zero flag, store data, destination register and MEM/WB
//   control bits, and presents them to the memory, write-back and
//   forwarding logic one cycle later. Supports hazard-unit stall (hold)
//   and flush (bubble), tracks a valid bit, and counts valid transfers.
//
// Parameters
//   DATA_W : width of ALU result and store data
//   REG_AW : register-file address width
//   CNT_W  : width of the valid-transfer counter
//
// Ports
//   clk_i          in   clock, rising edge active
//   rst_i          in   asynchronous active-low reset
//   stall_i        in   hold every register
//   flush_i        in   load a bubble (wins over stall_i)
//   valid_i        in   EX stage holds a real instruction
//   ALUResult_i    in   ALU result
//   Zero_i         in   ALU zero flag
//   RS2data_i      in   forwarded rs2 value (store data)
//   RDaddr_i       in   destination register
//   RegWrite_i     in   write-back enable
//   MemtoReg_i     in   WB selects memory data
//   MemRead_i      in   load
//   MemWrite_i     in   store
//   valid_o        out  MEM stage holds a real instruction
//   ALUResult_o    out  registered ALU result
//   Zero_o         out  registered zero flag
//   RS2data_o      out  registered store data
//   RDaddr_o       out  registered destination register
//   RegWrite_o     out  registered, qualified write-back enable
//   MemtoReg_o     out  registered MemtoReg
//   MemRead_o      out  registered, qualified load
//   MemWrite_o     out  registered, qualified store
//   xfer_cnt_o     out  number of valid instructions captured (wraps)
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic              Zero_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic              Zero_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [CNT_W-1:0]  xfer_cnt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   alu_result_q, alu_result_d;
    logic                zero_q, zero_d;
    logic [DATA_W-1:0]   rs2_data_q, rs2_data_d;
    logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;

    // Next-state selection. Everything defaults to holding its current value,
    // which is exactly the stall behaviour. A flush loads a full bubble (data
    // fields zeroed too, so stale values never leak to forwarding), and a
    // plain load captures the inputs with the control bits qualified: writes
    // to x0 are dropped, an invalid slot carries no side effects, and a
    // simultaneous load+store keeps only the store. Data fields load even for
    // an invalid slot since nothing downstream acts on them without control.
    always_comb begin
        state_d      = state_q;
        alu_result_d = alu_result_q;
        zero_d       = zero_q;
        rs2_data_d   = rs2_data_q;
        rd_addr_d    = rd_addr_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        xfer_cnt_d   = xfer_cnt_q;

        if (flush_i) begin
            state_d      = EMPTY;
            alu_result_d = '0;
            zero_d       = 1'b0;
            rs2_data_d   = '0;
            rd_addr_d    = '0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
        end else if (!stall_i) begin
            state_d      = valid_i ? FULL : EMPTY;
            alu_result_d = ALUResult_i;
            zero_d       = Zero_i;
            rs2_data_d   = RS2data_i;
            rd_addr_d    = RDaddr_i;
            reg_write_d  = RegWrite_i & valid_i & (RDaddr_i != '0);
            mem_to_reg_d = MemtoReg_i;
            mem_read_d   = MemRead_i & valid_i & ~MemWrite_i;
            mem_write_d  = MemWrite_i & valid_i;
            if (valid_i) begin
                xfer_cnt_d = xfer_cnt_q + 1'b1;
            end
        end
    end

    // State register. Reset is asynchronous so the outputs clear immediately,
    // discarding anything held during a stall; the hazard unit re-issues.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= EMPTY;
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            rs2_data_q   <= '0;
            rd_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            xfer_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            rs2_data_q   <= rs2_data_d;
            rd_addr_q    <= rd_addr_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign valid_o     = (state_q == FULL);
    assign ALUResult_o = alu_result_q;
    assign Zero_o      = zero_q;
    assign RS2data_o   = rs2_data_q;
    assign RDaddr_o    = rd_addr_q;
    assign RegWrite_o  = reg_write_q;
    assign MemtoReg_o  = mem_to_reg_q;
    assign MemRead_o   = mem_read_q;
    assign MemWrite_o  = mem_write_q;
    assign xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
//   Directed bench for ex_mem_reg. A default-width instance carries the main
//   checks; a second instance with a 4-bit counter shares the same inputs so
//   counter wrap can be observed without thousands of cycles.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] aluResult;
    logic        zero;
    logic [31:0] rs2Data;
    logic [4:0]  rdAddr;
    logic        regWrite;
    logic        memToReg;
    logic        memRead;
    logic        memWrite;

    logic        validOut;
    logic [31:0] aluResultOut;
    logic        zeroOut;
    logic [31:0] rs2DataOut;
    logic [4:0]  rdAddrOut;
    logic        regWriteOut;
    logic        memToRegOut;
    logic        memReadOut;
    logic        memWriteOut;
    logic [31:0] xferCnt;

    logic        wValid;
    logic [31:0] wAluResult;
    logic        wZero;
    logic [31:0] wRs2Data;
    logic [4:0]  wRdAddr;
    logic        wRegWrite;
    logic        wMemToReg;
    logic        wMemRead;
    logic        wMemWrite;
    logic [3:0]  wXferCnt;

    int nChecks = 0;
    int nErrors = 0;

    ex_mem_reg dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .ALUResult_i(aluResult), .Zero_i(zero),
        .RS2data_i(rs2Data), .RDaddr_i(rdAddr), .RegWrite_i(regWrite),
        .MemtoReg_i(memToReg), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .valid_o(validOut), .ALUResult_o(aluResultOut), .Zero_o(zeroOut),
        .RS2data_o(rs2DataOut), .RDaddr_o(rdAddrOut), .RegWrite_o(regWriteOut),
        .MemtoReg_o(memToRegOut), .MemRead_o(memReadOut),
        .MemWrite_o(memWriteOut), .xfer_cnt_o(xferCnt)
    );

    ex_mem_reg #(.CNT_W(4)) dutWrap (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .ALUResult_i(aluResult), .Zero_i(zero),
        .RS2data_i(rs2Data), .RDaddr_i(rdAddr), .RegWrite_i(regWrite),
        .MemtoReg_i(memToReg), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .valid_o(wValid), .ALUResult_o(wAluResult), .Zero_o(wZero),
        .RS2data_o(wRs2Data), .RDaddr_o(wRdAddr), .RegWrite_o(wRegWrite),
        .MemtoReg_o(wMemToReg), .MemRead_o(wMemRead),
        .MemWrite_o(wMemWrite), .xfer_cnt_o(wXferCnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every data/control input of the EX stage in one call.
    task automatic applyStimulus(input logic v, input logic [31:0] alu,
                                 input logic z, input logic [31:0] rs2,
                                 input logic [4:0] rd, input logic rw,
                                 input logic m2r, input logic mr,
                                 input logic mw);
        valid     = v;
        aluResult = alu;
        zero      = z;
        rs2Data   = rs2;
        rdAddr    = rd;
        regWrite  = rw;
        memToReg  = m2r;
        memRead   = mr;
        memWrite  = mw;
    endtask

    // One comparison: counts it, and on a miss counts the error and reports.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nErrors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks that every output of the main instance is zero.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"},    {63'd0, validOut},    64'd0);
        checkOutput({tag, " alu"},      {32'd0, aluResultOut}, 64'd0);
        checkOutput({tag, " zero"},     {63'd0, zeroOut},     64'd0);
        checkOutput({tag, " rs2"},      {32'd0, rs2DataOut},  64'd0);
        checkOutput({tag, " rd"},       {59'd0, rdAddrOut},   64'd0);
        checkOutput({tag, " regwrite"}, {63'd0, regWriteOut}, 64'd0);
        checkOutput({tag, " memtoreg"}, {63'd0, memToRegOut}, 64'd0);
        checkOutput({tag, " memread"},  {63'd0, memReadOut},  64'd0);
        checkOutput({tag, " memwrite"}, {63'd0, memWriteOut}, 64'd0);
        checkOutput({tag, " cnt"},      {32'd0, xferCnt},     64'd0);
        checkOutput({tag, " wrapcnt"},  {60'd0, wXferCnt},    64'd0);
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low with busy inputs: outputs zero at once and per edge.
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hCAFE_F00D, 5'd9,
                      1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checkAllZero("reset_now");
        stepClock();
        checkAllZero("reset_edge1");
        stepClock();
        checkAllZero("reset_edge2");

        // Basic load.
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000, 5'd5,
                      1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        stepClock();
        checkOutput("load alu",      {32'd0, aluResultOut}, 64'h10);
        checkOutput("load rd",       {59'd0, rdAddrOut},    64'd5);
        checkOutput("load regwrite", {63'd0, regWriteOut},  64'd1);
        checkOutput("load valid",    {63'd0, validOut},     64'd1);
        checkOutput("load zero",     {63'd0, zeroOut},      64'd1);
        checkOutput("load cnt",      {32'd0, xferCnt},      64'd1);

        // Write to x0 suppressed; load+store keeps only the store.
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_0020, 1'b0, 32'h1111_2222, 5'd0,
                      1'b1, 1'b0, 1'b1, 1'b1);
        stepClock();
        checkOutput("x0 regwrite",   {63'd0, regWriteOut},  64'd0);
        checkOutput("ill memread",   {63'd0, memReadOut},   64'd0);
        checkOutput("ill memwrite",  {63'd0, memWriteOut},  64'd1);
        checkOutput("ill rs2",       {32'd0, rs2DataOut},   64'h1111_2222);
        checkOutput("ill cnt",       {32'd0, xferCnt},      64'd2);

        // Invalid slot: data loads, side effects masked, counter holds.
        @(negedge clk);
        applyStimulus(1'b0, 32'h0000_1234, 1'b0, 32'h0, 5'd3,
                      1'b1, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("inv valid",     {63'd0, validOut},     64'd0);
        checkOutput("inv alu",       {32'd0, aluResultOut}, 64'h1234);
        checkOutput("inv rd",        {59'd0, rdAddrOut},    64'd3);
        checkOutput("inv regwrite",  {63'd0, regWriteOut},  64'd0);
        checkOutput("inv memwrite",  {63'd0, memWriteOut},  64'd0);
        checkOutput("inv memtoreg",  {63'd0, memToRegOut},  64'd1);
        checkOutput("inv cnt",       {32'd0, xferCnt},      64'd2);

        // Load 0xAAAA_AAAA, then stall three cycles with new inputs waiting.
        @(negedge clk);
        applyStimulus(1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0, 5'd7,
                      1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("pre-stall cnt", {32'd0, xferCnt},      64'd3);
        @(negedge clk);
        stall = 1'b1;
        applyStimulus(1'b1, 32'h5555_5555, 1'b1, 32'h0000_DEAD, 5'd7,
                      1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("stall alu",     {32'd0, aluResultOut}, 64'hAAAA_AAAA);
            checkOutput("stall cnt",     {32'd0, xferCnt},      64'd3);
            checkOutput("stall memread", {63'd0, memReadOut},   64'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        stepClock();
        checkOutput("unstall alu",     {32'd0, aluResultOut}, 64'h5555_5555);
        checkOutput("unstall memread", {63'd0, memReadOut},   64'd1);
        checkOutput("unstall cnt",     {32'd0, xferCnt},      64'd4);

        // Flush wins over stall on FULL contents; counter holds.
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        stepClock();
        checkOutput("flush valid",    {63'd0, validOut},     64'd0);
        checkOutput("flush regwrite", {63'd0, regWriteOut},  64'd0);
        checkOutput("flush memread",  {63'd0, memReadOut},   64'd0);
        checkOutput("flush memwrite", {63'd0, memWriteOut},  64'd0);
        checkOutput("flush memtoreg", {63'd0, memToRegOut},  64'd0);
        checkOutput("flush alu",      {32'd0, aluResultOut}, 64'd0);
        checkOutput("flush zero",     {63'd0, zeroOut},      64'd0);
        checkOutput("flush rs2",      {32'd0, rs2DataOut},   64'd0);
        checkOutput("flush rd",       {59'd0, rdAddrOut},    64'd0);
        checkOutput("flush cnt",      {32'd0, xferCnt},      64'd4);

        // 12 more valid loads: 16 in total, so the 4-bit counter wraps to 0.
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b1, 32'h0000_0042, 1'b0, 32'h0, 5'd1,
                      1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            stepClock();
        end
        checkOutput("wrap cnt15",   {60'd0, wXferCnt}, 64'd15);
        stepClock();
        checkOutput("wrap cnt0",    {60'd0, wXferCnt}, 64'd0);
        checkOutput("wide cnt16",   {32'd0, xferCnt},  64'd16);

        // Reset between edges (mid-stall): outputs clear without a clock edge.
        stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async_reset");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
